// File: rtl/rx_buf_pkg.sv
// Shared constants, types and the slot-length to word-count helper for the
// rx buffer read sequencer.
package rx_buf_pkg;

    localparam int BANK_WORDS    = 128;
    localparam int SLOT_OVERHEAD = 40;
    localparam int HDR_BYTES     = 4;
    localparam int BUF_ADDR_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic       len_err;
        logic [7:0] words;
    } word_count_t;

    // Short or oversized slots fall back to draining the whole bank.
    function automatic word_count_t calc_words(input logic [8:0] slot_len);
        word_count_t res;
        logic [9:0]  raw;
        logic [9:0]  words;
        raw         = {1'b0, slot_len} - 10'(SLOT_OVERHEAD) + 10'(HDR_BYTES) + 10'd3;
        words       = raw >> 2;
        res.len_err = ({1'b0, slot_len} < 10'(SLOT_OVERHEAD + 1)) ||
                      (words > 10'(BANK_WORDS));
        res.words   = res.len_err ? 8'(BANK_WORDS) : words[7:0];
        return res;
    endfunction

endpackage

// File: rtl/rx_bank_queue.sv
// One-entry pending-bank slot: assigns alternating banks to interrupts and
// counts interrupts that arrive while the slot is still occupied.
module rx_bank_queue
    import rx_buf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_words,
    input  logic       push_len_err,
    input  logic       pop,
    output logic       pend_valid,
    output logic       pend_bank,
    output logic [7:0] pend_words,
    output logic       len_err,
    output logic       overrun,
    output logic [7:0] overrun_cnt
);

    logic       pend_valid_q, pend_valid_d;
    logic       pend_bank_q, pend_bank_d;
    logic [7:0] pend_words_q, pend_words_d;
    logic       next_bank_q, next_bank_d;
    logic       len_err_q, len_err_d;
    logic       overrun_q, overrun_d;
    logic [7:0] overrun_cnt_q, overrun_cnt_d;

    // A push in the same cycle as a pop refills the slot instead of dropping.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_bank_d   = pend_bank_q;
        pend_words_d  = pend_words_q;
        next_bank_d   = next_bank_q;
        len_err_d     = len_err_q;
        overrun_d     = overrun_q;
        overrun_cnt_d = overrun_cnt_q;
        if (pop) begin
            pend_valid_d = 1'b0;
        end
        if (push) begin
            next_bank_d = ~next_bank_q;
            if (push_len_err) begin
                len_err_d = 1'b1;
            end
            if (!pend_valid_q || pop) begin
                pend_valid_d = 1'b1;
                pend_bank_d  = next_bank_q;
                pend_words_d = push_words;
            end else begin
                overrun_d = 1'b1;
                if (overrun_cnt_q != 8'hFF) begin
                    overrun_cnt_d = overrun_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_bank_q   <= 1'b0;
            pend_words_q  <= '0;
            next_bank_q   <= 1'b0;
            len_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_bank_q   <= pend_bank_d;
            pend_words_q  <= pend_words_d;
            next_bank_q   <= next_bank_d;
            len_err_q     <= len_err_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign pend_valid  = pend_valid_q;
    assign pend_bank   = pend_bank_q;
    assign pend_words  = pend_words_q;
    assign len_err     = len_err_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: rtl/rx_buffer_rd_ctrl.sv
// Drains completed ping-pong rx banks word by word from the 32-bit RAM read
// port onto a valid/ready stream, header word first.
module rx_buffer_rd_ctrl
    import rx_buf_pkg::*;
#(
    parameter int RAM_LAT = 1
) (
    input  logic        logic_clk_in,
    input  logic        logic_rst_in,
    input  logic        rx_slot_interrupt_in,
    input  logic [8:0]  rx_slot_length,
    output logic        ram_rd_out,
    output logic [7:0]  addr_rd_out,
    input  logic [31:0] ram_data_in,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout_data,
    output logic        dout_first,
    output logic        dout_last,
    output logic        dout_bank,
    output logic        busy_out,
    output logic        overrun_out,
    output logic [7:0]  overrun_cnt,
    output logic [31:0] debug_signal
);

    rd_state_t             state_q, state_d;
    logic                  bank_q, bank_d;
    logic [7:0]            words_q, words_d;
    logic [6:0]            rd_cnt_q, rd_cnt_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic                  ram_rd_q, ram_rd_d;
    logic [BUF_ADDR_W-1:0] addr_q, addr_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [31:0]           dout_data_q, dout_data_d;
    logic                  dout_first_q, dout_first_d;
    logic                  dout_last_q, dout_last_d;
    logic                  dout_bank_q, dout_bank_d;

    logic                  pop;
    word_count_t           wc;
    logic                  pend_valid;
    logic                  pend_bank;
    logic [7:0]            pend_words;
    logic                  len_err;

    assign wc = calc_words(rx_slot_length);

    rx_bank_queue u_queue (
        .clk          (logic_clk_in),
        .rst          (logic_rst_in),
        .push         (rx_slot_interrupt_in),
        .push_words   (wc.words),
        .push_len_err (wc.len_err),
        .pop          (pop),
        .pend_valid   (pend_valid),
        .pend_bank    (pend_bank),
        .pend_words   (pend_words),
        .len_err      (len_err),
        .overrun      (overrun_out),
        .overrun_cnt  (overrun_cnt)
    );

    // Read request and address are registered on entry to ISSUE so the RAM
    // sees them exactly for the one ISSUE cycle.
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        words_d      = words_q;
        rd_cnt_d     = rd_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        ram_rd_d     = 1'b0;
        addr_d       = addr_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_first_d = dout_first_q;
        dout_last_d  = dout_last_q;
        dout_bank_d  = dout_bank_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_valid) begin
                    pop      = 1'b1;
                    bank_d   = pend_bank;
                    words_d  = pend_words;
                    rd_cnt_d = '0;
                    ram_rd_d = 1'b1;
                    addr_d   = {pend_bank, 7'd0};
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == 2'(RAM_LAT - 1)) begin
                    dout_data_d  = ram_data_in;
                    dout_first_d = (rd_cnt_q == 7'd0);
                    dout_last_d  = ({1'b0, rd_cnt_q} == (words_q - 8'd1));
                    dout_bank_d  = bank_q;
                    dout_valid_d = 1'b1;
                    state_d      = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            HOLD: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    if (dout_last_q) begin
                        state_d = IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 7'd1;
                        ram_rd_d = 1'b1;
                        addr_d   = {bank_q, rd_cnt_q + 7'd1};
                        state_d  = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            state_q      <= IDLE;
            bank_q       <= 1'b0;
            words_q      <= '0;
            rd_cnt_q     <= '0;
            wait_cnt_q   <= '0;
            ram_rd_q     <= 1'b0;
            addr_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_first_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_bank_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            words_q      <= words_d;
            rd_cnt_q     <= rd_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            ram_rd_q     <= ram_rd_d;
            addr_q       <= addr_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_first_q <= dout_first_d;
            dout_last_q  <= dout_last_d;
            dout_bank_q  <= dout_bank_d;
        end
    end

    assign ram_rd_out   = ram_rd_q;
    assign addr_rd_out  = addr_q;
    assign dout_valid   = dout_valid_q;
    assign dout_data    = dout_data_q;
    assign dout_first   = dout_first_q;
    assign dout_last    = dout_last_q;
    assign dout_bank    = dout_bank_q;
    assign busy_out     = (state_q != IDLE) || pend_valid;
    assign debug_signal = {12'd0, len_err, state_q, rd_cnt_q, words_q, pend_valid, bank_q};

endmodule
